// File: rtl/sequential_divider.sv
// Four-bit unsigned restoring divider, one quotient bit per clock, start/done handshake.
// Optional divide-by-zero early exit and dbz flag: define SEQDIV_DBZ_FLAG_EN.
module sequential_divider (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic       busy,
  output logic       done,
  output logic [3:0] quotient,
  output logic [3:0] remainder
`ifdef SEQDIV_DBZ_FLAG_EN
  ,
  output logic       dbz
`endif
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
`ifdef SEQDIV_DBZ_FLAG_EN
    ,
    S_DBZ  = 2'd2
`endif
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  dvd_q, dvd_d;
  logic [3:0]  dvs_q, dvs_d;
  logic [4:0]  p_q, p_d;
  logic [3:0]  qsr_q, qsr_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [3:0]  quo_q, quo_d;
  logic [3:0]  rem_q, rem_d;
`ifdef SEQDIV_DBZ_FLAG_EN
  logic        dbz_q, dbz_d;
`endif

  logic [4:0]  p_shift;
  logic [5:0]  diff;
  logic [4:0]  p_step;
  logic [3:0]  qsr_step;
  logic        unused_p_msb;

  // P < b after every step, so only P[3:0] ever feeds the next shift.
  assign unused_p_msb = p_q[4];
  assign p_shift      = {p_q[3:0], dvd_q[cnt_q]};
  assign diff         = {1'b0, p_shift} - {2'b00, dvs_q};

  always_comb begin
    qsr_step        = qsr_q;
    qsr_step[cnt_q] = ~diff[5];
    p_step          = diff[5] ? p_shift : diff[4:0];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef SEQDIV_DBZ_FLAG_EN
          if (b == 4'd0) state_d = S_DBZ;
          else           state_d = S_RUN;
`else
          state_d = S_RUN;
`endif
        end
      end
      S_RUN:   if (cnt_q == 2'd0) state_d = S_IDLE;
`ifdef SEQDIV_DBZ_FLAG_EN
      S_DBZ:   state_d = S_IDLE;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next-values; every output is a register fed from here
  always_comb begin
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    p_d    = p_q;
    qsr_d  = qsr_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    quo_d  = quo_q;
    rem_d  = rem_q;
`ifdef SEQDIV_DBZ_FLAG_EN
    dbz_d  = dbz_q;
`endif
    busy_d = (state_d == S_RUN);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          dvd_d = a;
          dvs_d = b;
          p_d   = '0;
          qsr_d = '0;
          cnt_d = 2'd3;
`ifdef SEQDIV_DBZ_FLAG_EN
          dbz_d = 1'b0;
`endif
        end
      end
      S_RUN: begin
        p_d   = p_step;
        qsr_d = qsr_step;
        cnt_d = cnt_q - 2'd1;
        if (cnt_q == 2'd0) begin
          quo_d  = qsr_step;
          rem_d  = p_step[3:0];
          done_d = 1'b1;
        end
      end
`ifdef SEQDIV_DBZ_FLAG_EN
      S_DBZ: begin
        quo_d  = '1;
        rem_d  = dvd_q;
        dbz_d  = 1'b1;
        done_d = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dvd_q  <= '0;
      dvs_q  <= '0;
      p_q    <= '0;
      qsr_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
`ifdef SEQDIV_DBZ_FLAG_EN
      dbz_q  <= 1'b0;
`endif
    end else begin
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      p_q    <= p_d;
      qsr_q  <= qsr_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
`ifdef SEQDIV_DBZ_FLAG_EN
      dbz_q  <= dbz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;
`ifdef SEQDIV_DBZ_FLAG_EN
  assign dbz       = dbz_q;
`endif

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: vector table, hand-written corner sequences,
// randomized and exhaustive back-to-back divisions against an arithmetic reference.
module tb_sequential_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] b = '0;
  logic       busy, done;
  logic [3:0] quotient, remainder;
`ifdef SEQDIV_DBZ_FLAG_EN
  logic       dbz;
`endif

  int checks   = 0;
  int failures = 0;

  sequential_divider dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder)
`ifdef SEQDIV_DBZ_FLAG_EN
    ,
    .dbz       (dbz)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  function automatic void ref_div(input int unsigned x, input int unsigned y,
                                  output logic [3:0] q, output logic [3:0] r);
    if (y == 0) begin
      q = 4'd15;
      r = x[3:0];
    end else begin
      q = 4'(x / y);
      r = 4'(x % y);
    end
  endfunction

  function automatic int exp_latency(input logic [3:0] y);
`ifdef SEQDIV_DBZ_FLAG_EN
    if (y == 4'd0) return 1;
`endif
    return 4;
  endfunction

  // Starts one division, reports latency (edges after the start edge until done is seen)
  // and counts protocol violations: wrong busy, results changing before done, done too long.
  task automatic run_one(input logic [3:0] ta, input logic [3:0] tb,
                         output logic [3:0] q, output logic [3:0] r,
                         output int lat, output int errs);
    logic [3:0] hq, hr;
    logic       exp_busy;
    exp_busy = (exp_latency(tb) == 4);
    errs = 0;
    @(negedge clk);
    a = ta; b = tb; start = 1'b1;
    hq = quotient; hr = remainder;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 20) begin
      if (busy !== exp_busy || quotient !== hq || remainder !== hr) errs++;
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    if (busy !== 1'b0) errs++;
    q = quotient;
    r = remainder;
    @(posedge clk);
    @(negedge clk);
    if (done !== 1'b0 || quotient !== q || remainder !== r) errs++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  vec_t vecs[8];
  vec_t ops[$];

  initial begin
    logic [3:0] q, r, eq, er;
    int lat, errs, ndone, cyc, idx, guard, latbad, dcount;

    vecs[0] = '{4'd13, 4'd3,  4'd4,  4'd1};
    vecs[1] = '{4'd15, 4'd1,  4'd15, 4'd0};
    vecs[2] = '{4'd2,  4'd7,  4'd0,  4'd2};
    vecs[3] = '{4'd9,  4'd0,  4'd15, 4'd9};
    vecs[4] = '{4'd14, 4'd4,  4'd3,  4'd2};
    vecs[5] = '{4'd11, 4'd2,  4'd5,  4'd1};
    vecs[6] = '{4'd0,  4'd5,  4'd0,  4'd0};
    vecs[7] = '{4'd15, 4'd15, 4'd1,  4'd0};

    do_reset();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
`ifdef SEQDIV_DBZ_FLAG_EN
    check("reset_dbz", dbz, 0);
`endif

    foreach (vecs[i]) begin
      run_one(vecs[i].a, vecs[i].b, q, r, lat, errs);
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].b));
      check($sformatf("vec%0d_protocol", i), errs, 0);
`ifdef SEQDIV_DBZ_FLAG_EN
      check($sformatf("vec%0d_dbz", i), dbz, (vecs[i].b == 4'd0) ? 1 : 0);
`endif
    end

    // start re-pulsed at N+2 while busy must be ignored
    @(negedge clk);
    a = 4'd14; b = 4'd4; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk); a = 4'd1; b = 4'd1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0; a = '0; b = '0;
    lat = 2;
    while (!done && lat < 20) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    check("restart_latency", lat, 4);
    check("restart_quotient", quotient, 3);
    check("restart_remainder", remainder, 2);
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcount++;
    end
    check("restart_no_second_done", dcount, 0);

    // reset between N+2 and N+3 abandons the division
    @(negedge clk);
    a = 4'd11; b = 4'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("midreset_busy", busy, 0);
    check("midreset_done", done, 0);
    check("midreset_quotient", quotient, 0);
    check("midreset_remainder", remainder, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done || busy) dcount++;
    end
    check("midreset_idle_after", dcount, 0);
    run_one(4'd11, 4'd2, q, r, lat, errs);
    check("postreset_quotient", q, 5);
    check("postreset_remainder", r, 1);
    check("postreset_latency", lat, 4);

    // randomized operands, b=0 included
    for (int i = 0; i < 40; i++) begin
      logic [3:0] ra, rb;
      ra = 4'($urandom_range(0, 15));
      rb = (i % 8 == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      ref_div(ra, rb, eq, er);
      run_one(ra, rb, q, r, lat, errs);
      check($sformatf("rand%0d_%0d/%0d_q", i, ra, rb), q, eq);
      check($sformatf("rand%0d_%0d/%0d_r", i, ra, rb), r, er);
      check($sformatf("rand%0d_latency", i), lat, exp_latency(rb));
      check($sformatf("rand%0d_protocol", i), errs, 0);
    end

    // exhaustive b!=0, each start issued in the cycle done is seen
    for (int x = 0; x < 16; x++)
      for (int y = 1; y < 16; y++)
        ops.push_back('{4'(x), 4'(y), 4'd0, 4'd0});
    @(negedge clk);
    a = ops[0].a; b = ops[0].b; start = 1'b1;
    idx = 1; ndone = 0; cyc = 0; guard = 0; latbad = 0;
    while (ndone < ops.size() && guard < 3000) begin
      @(posedge clk);
      cyc++;
      guard++;
      @(negedge clk);
      if (done) begin
        ref_div(ops[ndone].a, ops[ndone].b, eq, er);
        check($sformatf("b2b_%0d/%0d_q", ops[ndone].a, ops[ndone].b), quotient, eq);
        check($sformatf("b2b_%0d/%0d_r", ops[ndone].a, ops[ndone].b), remainder, er);
        if (cyc != 5) latbad++;
        ndone++;
        if (idx < ops.size()) begin
          a = ops[idx].a; b = ops[idx].b; start = 1'b1;
          idx++;
          cyc = 0;
        end else begin
          start = 1'b0;
        end
      end else begin
        start = 1'b0;
      end
    end
    check("b2b_done_count", ndone, ops.size());
    check("b2b_latency_errors", latbad, 0);
    dcount = 0;
    repeat (8) begin
      @(posedge clk);
      @(negedge clk);
      if (done) dcount++;
    end
    check("b2b_no_extra_done", dcount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
